// File: rtl/mat_row_mem_pkg.sv
// mat_row_mem_pkg: shared state encodings, default sizes and the INIT fill pattern.
package mat_row_mem_pkg;

   localparam int DEF_DATA_LEN     = 32;
   localparam int DEF_N            = 8;
   localparam int DEF_M            = 8;
   localparam int DEF_ADDRESS_SIZE = 4;

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      READY  = 2'd1,
      DUMP   = 2'd2,
      UNUSED = 2'd3
   } state_t;

   // Element c of row r after INIT: the top half of the array is cleared.
   function automatic int unsigned init_elem(input int unsigned r, input int unsigned c,
                                             input int unsigned n, input int unsigned m);
      return (r < m) ? r * n + c : 0;
   endfunction

endpackage

// File: rtl/mat_row_ram.sv
// mat_row_ram: row storage with one sync write port and two registered read ports.
module mat_row_ram #(
   parameter int W     = 256,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [W-1:0]  wd,
   input  logic          ra_en,
   input  logic [AW-1:0] ra,
   output logic [W-1:0]  rq,
   input  logic          rb_en,
   input  logic [AW-1:0] rb,
   output logic [W-1:0]  rbq
);

   logic [W-1:0] mem [DEPTH];

   // The array itself is never reset; only the read registers are.
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq  <= '0;
         rbq <= '0;
      end else begin
         if (ra_en) rq <= mem[ra];
         if (rb_en) rbq <= mem[rb];
      end
   end

endmodule

// File: rtl/mat_row_mem.sv
// mat_row_mem: matrix row store that self-initialises, serves row reads/writes,
// and streams every row out on a controller done pulse.
module mat_row_mem
   import mat_row_mem_pkg::*;
#(
   parameter int DATA_LEN     = DEF_DATA_LEN,
   parameter int N            = DEF_N,
   parameter int M            = DEF_M,
   parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE
) (
   input  logic                      i_clk,
   input  logic                      i_rstn,
   input  logic [ADDRESS_SIZE-1:0]   i_address,
   input  logic                      i_wr_en,
   input  logic [DATA_LEN*N-1:0]     i_write_data,
   output logic [DATA_LEN*N-1:0]     o_read_data,
   output logic                      o_rd_valid,
   output logic                      o_ready,
   input  logic                      i_done,
   output logic [DATA_LEN*N-1:0]     o_dump_data,
   output logic [ADDRESS_SIZE-1:0]   o_dump_row,
   output logic                      o_dump_valid,
   output logic [1:0]                o_state
);

   localparam int W    = DATA_LEN * N;
   localparam int ROWS = 2 * M;
   localparam logic [ADDRESS_SIZE-1:0] LAST = ADDRESS_SIZE'(ROWS - 1);

   state_t                  state;
   logic [ADDRESS_SIZE-1:0] cnt;
   logic [W-1:0]            fill;
   logic                    we;
   logic [ADDRESS_SIZE-1:0] wa;
   logic [W-1:0]            wd;
   logic                    ra_en;

   always_comb begin
      fill = '0;
      for (int c = 0; c < N; c++)
         fill[DATA_LEN*c +: DATA_LEN] = DATA_LEN'(init_elem(32'(cnt), c, N, M));
   end

   // INIT owns the write port; the controller only gets it in READY.
   assign we    = (state == INIT) || (state == READY && i_wr_en);
   assign wa    = (state == INIT) ? cnt : i_address;
   assign wd    = (state == INIT) ? fill : i_write_data;
   assign ra_en = (state == READY) && !i_wr_en && !i_done;

   assign o_ready = (state == READY);
   assign o_state = state;

   mat_row_ram #(.W(W), .DEPTH(ROWS), .AW(ADDRESS_SIZE)) u_ram (
      .clk   (i_clk),
      .rst_n (i_rstn),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .ra_en (ra_en),
      .ra    (i_address),
      .rq    (o_read_data),
      .rb_en (state == DUMP),
      .rb    (cnt),
      .rbq   (o_dump_data)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state        <= INIT;
         cnt          <= '0;
         o_rd_valid   <= 1'b0;
         o_dump_valid <= 1'b0;
         o_dump_row   <= '0;
      end else begin
         o_rd_valid   <= 1'b0;
         o_dump_valid <= 1'b0;
         case (state)
            INIT: begin
               cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
               state <= (cnt == LAST) ? READY : INIT;
            end
            READY: begin
               o_rd_valid <= !(i_wr_en || i_done);
               cnt        <= '0;
               state      <= i_done ? DUMP : READY;
            end
            DUMP: begin
               o_dump_valid <= 1'b1;
               o_dump_row   <= cnt;
               cnt          <= (cnt == LAST) ? '0 : cnt + 1'b1;
               state        <= (cnt == LAST) ? READY : DUMP;
            end
            default: begin
               cnt   <= '0;
               state <= INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mat_row_mem.sv
// tb_mat_row_mem: directed, table-driven check of init, read/write, dump and reset abort.
module tb_mat_row_mem;

   localparam int DW = 256;

   logic          i_clk = 1'b0;
   logic          i_rstn;
   logic [3:0]    i_address;
   logic          i_wr_en;
   logic [DW-1:0] i_write_data;
   logic [DW-1:0] o_read_data;
   logic          o_rd_valid;
   logic          o_ready;
   logic          i_done;
   logic [DW-1:0] o_dump_data;
   logic [3:0]    o_dump_row;
   logic          o_dump_valid;
   logic [1:0]    o_state;

   int total = 0;
   int bad   = 0;

   mat_row_mem dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_address    (i_address),
      .i_wr_en      (i_wr_en),
      .i_write_data (i_write_data),
      .o_read_data  (o_read_data),
      .o_rd_valid   (o_rd_valid),
      .o_ready      (o_ready),
      .i_done       (i_done),
      .o_dump_data  (o_dump_data),
      .o_dump_row   (o_dump_row),
      .o_dump_valid (o_dump_valid),
      .o_state      (o_state)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic          wr;
      logic [3:0]    addr;
      logic [DW-1:0] wd;
      logic          ev;
      logic [DW-1:0] ed;
   } vec_t;

   vec_t          vt [9];
   logic [DW-1:0] mdl [16];
   logic [DW-1:0] a5;
   logic [DW-1:0] xr;
   logic [DW-1:0] ones;

   function automatic logic [DW-1:0] pat(input int r);
      logic [DW-1:0] p;
      p = '0;
      for (int c = 0; c < 8; c++) p[32*c +: 32] = (r < 8) ? 32'(r * 8 + c) : 32'd0;
      return p;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      while (!o_ready && n < 40) begin
         i_wr_en = (n == 3);
         tick();
         if (n < 15) chk("init_state", DW'(o_state), DW'(0));
         n++;
      end
      i_wr_en = 1'b0;
      chk("init_cycles", DW'(n), DW'(16));
      chk("ready_state", DW'(o_state), DW'(1));
   endtask

   task automatic rd(input string name, input logic [3:0] a, input logic [DW-1:0] exp);
      i_wr_en   = 1'b0;
      i_done    = 1'b0;
      i_address = a;
      tick();
      chk({name, "_valid"}, DW'(o_rd_valid), DW'(1));
      chk({name, "_data"}, o_read_data, exp);
   endtask

   initial begin
      int beats;
      int k;
      a5   = {8{32'hA5A5A5A5}};
      xr   = {8{32'h1234_5678}};
      ones = '1;
      for (int r = 0; r < 16; r++) mdl[r] = pat(r);
      vt[0] = '{1'b0, 4'd1,  '0, 1'b1, pat(1)};
      vt[1] = '{1'b0, 4'd0,  '0, 1'b1, pat(0)};
      vt[2] = '{1'b1, 4'd9,  a5, 1'b0, pat(0)};
      vt[3] = '{1'b0, 4'd9,  '0, 1'b1, a5};
      vt[4] = '{1'b0, 4'd15, '0, 1'b1, '0};
      vt[5] = '{1'b0, 4'd7,  '0, 1'b1, pat(7)};
      vt[6] = '{1'b1, 4'd3,  xr, 1'b0, pat(7)};
      vt[7] = '{1'b0, 4'd3,  '0, 1'b1, xr};
      vt[8] = '{1'b0, 4'd8,  '0, 1'b1, '0};

      i_rstn = 1'b0; i_address = '0; i_wr_en = 1'b0; i_write_data = '0; i_done = 1'b0;
      #2;
      chk("rst_state", DW'(o_state), DW'(0));
      chk("rst_ready", DW'(o_ready), DW'(0));
      chk("rst_rd_valid", DW'(o_rd_valid), DW'(0));
      chk("rst_read_data", o_read_data, '0);
      chk("rst_dump_valid", DW'(o_dump_valid), DW'(0));
      chk("rst_dump_row", DW'(o_dump_row), DW'(0));
      chk("rst_dump_data", o_dump_data, '0);
      #8 i_rstn = 1'b1;
      wait_init();

      for (int i = 0; i < 9; i++) begin
         i_wr_en = vt[i].wr; i_address = vt[i].addr; i_write_data = vt[i].wd; i_done = 1'b0;
         tick();
         if (vt[i].wr) mdl[vt[i].addr] = vt[i].wd;
         chk($sformatf("vec%0d_valid", i), DW'(o_rd_valid), DW'(vt[i].ev));
         chk($sformatf("vec%0d_data", i), o_read_data, vt[i].ed);
      end

      for (int i = 0; i < 16; i++) rd($sformatf("b2b%0d", i), 4'(i), mdl[i]);

      i_wr_en = 1'b1; i_address = 4'd15; i_write_data = ones; i_done = 1'b1;
      tick();
      mdl[15] = ones;
      chk("done_state", DW'(o_state), DW'(2));
      chk("done_no_read", DW'(o_rd_valid), DW'(0));
      chk("dump_not_ready", DW'(o_ready), DW'(0));
      beats = 0; k = 0;
      while (beats < 16 && k < 40) begin
         i_done = (k < 3); i_wr_en = (k < 3); i_address = 4'd2; i_write_data = '0;
         tick();
         if (o_dump_valid) begin
            chk($sformatf("dump%0d_row", beats), DW'(o_dump_row), DW'(beats));
            chk($sformatf("dump%0d_data", beats), o_dump_data, mdl[beats]);
            beats++;
         end
         k++;
      end
      chk("dump_beats", DW'(beats), DW'(16));
      chk("dump_end_state", DW'(o_state), DW'(1));
      rd("after_dump_row2", 4'd2, mdl[2]);
      chk("dump_valid_drop", DW'(o_dump_valid), DW'(0));

      i_done = 1'b1;
      tick();
      i_done = 1'b0;
      k = 0;
      while (!(o_dump_valid && o_dump_row == 4'd5) && k < 40) begin
         tick();
         k++;
      end
      chk("reach_beat5", DW'(k < 40), DW'(1));
      i_rstn = 1'b0;
      #1;
      chk("abort_dump_valid", DW'(o_dump_valid), DW'(0));
      chk("abort_state", DW'(o_state), DW'(0));
      chk("abort_dump_data", o_dump_data, '0);
      chk("abort_read_data", o_read_data, '0);
      @(negedge i_clk);
      i_rstn = 1'b1;
      for (int r = 0; r < 16; r++) mdl[r] = pat(r);
      wait_init();
      rd("reinit_row15", 4'd15, '0);
      rd("reinit_row9", 4'd9, '0);
      rd("reinit_row1", 4'd1, pat(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
